// File: rtl/sdram_pkg.sv
// sdram_pkg: shared state encodings, address field layout and SDRAM command codes
package sdram_pkg;
    localparam int ADDR_W_DEF = 24;
    localparam int LEN_W_DEF  = 9;
    // Address layout {bank[1:0], row[12:0], col[8:0]}
    localparam int COL_LSB = 0;
    localparam int COL_W   = 9;
    localparam int ROW_LSB = 9;
    localparam int ROW_W   = 13;
    localparam int BA_LSB  = 22;
    localparam int BA_W    = 2;

    typedef enum logic [5:0] {
        ST_WAIT_INIT = 6'b000001,
        ST_IDLE      = 6'b000010,
        ST_ISSUE     = 6'b000100,
        ST_BUSY      = 6'b001000,
        ST_COMPLETE  = 6'b010000,
        ST_REFRESH   = 6'b100000
    } arb_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WRITE = 4'b0100,
        CMD_READ  = 4'b0101,
        CMD_NOP   = 4'b0111
    } sdram_cmd_t;

    function automatic logic [BA_W-1:0] addr_bank(input logic [ADDR_W_DEF-1:0] a);
        return a[BA_LSB +: BA_W];
    endfunction
endpackage

// File: rtl/sdram_rr_pick.sv
// sdram_rr_pick: combinational round-robin picker, first request at or above i_rr_ptr with wrap
module sdram_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_win_oh,
    output logic [PW-1:0] o_win_idx,
    output logic          o_any
);
    always_comb begin
        int w_idx;
        o_win_oh  = '0;
        o_win_idx = '0;
        o_any     = |i_req;
        // Scan farthest-first so the nearest request above the pointer is written last
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_rr_ptr) + k) % N;
            if (i_req[w_idx]) begin
                o_win_oh  = {{(N-1){1'b0}}, 1'b1} << w_idx;
                o_win_idx = PW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin scheduler sharing one SDRAM command path among NUM_PORTS
// clients, with auto-refresh taking priority at command boundaries.
module sdram_port_arb
    import sdram_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_done,
    input  logic                          aref_req,
    output logic                          aref_ack,
    input  logic                          aref_done,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [NUM_PORTS-1:0]          port_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]    port_len,
    output logic [NUM_PORTS-1:0]          port_gnt,
    output logic [NUM_PORTS-1:0]          port_done,
    output logic                          ctl_valid,
    output logic                          ctl_we,
    output logic [ADDR_W-1:0]             ctl_addr,
    output logic [LEN_W-1:0]              ctl_len,
    input  logic                          ctl_ready,
    input  logic                          ctl_done,
    output logic                          busy
);
    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_pick_oh;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_any;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LEN_W-1:0]     w_sel_len;

    arb_state_t           r_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] r_win_oh;
    logic [PTR_W-1:0]     r_win_idx;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;
    logic                 r_ctl_valid;
    logic                 r_aref_ack;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [NUM_PORTS-1:0] r_done;
    logic                 r_busy;

    sdram_rr_pick #(.N(NUM_PORTS), .PW(PTR_W)) u_pick (
        .i_req     (port_req),
        .i_rr_ptr  (r_rr_ptr),
        .o_win_oh  (w_pick_oh),
        .o_win_idx (w_pick_idx),
        .o_any     (w_any)
    );

    assign w_sel_addr = port_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_len  = port_len[w_pick_idx*LEN_W +: LEN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_WAIT_INIT;
            r_rr_ptr    <= '0;
            r_win_oh    <= '0;
            r_win_idx   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_ctl_valid <= 1'b0;
            r_aref_ack  <= 1'b0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                ST_WAIT_INIT: begin
                    r_busy <= !init_done;
                    if (init_done) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_busy <= aref_req || w_any;
                    if (aref_req) begin
                        r_aref_ack <= 1'b1;
                        r_state    <= ST_REFRESH;
                    end else if (w_any) begin
                        r_win_oh    <= w_pick_oh;
                        r_win_idx   <= w_pick_idx;
                        r_we        <= port_we[w_pick_idx];
                        r_addr      <= w_sel_addr;
                        r_len       <= w_sel_len;
                        r_ctl_valid <= |w_sel_len;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_busy <= 1'b1;
                    // A zero-length request is granted and retired without touching the controller
                    if (r_len == '0) begin
                        r_gnt   <= r_win_oh;
                        r_state <= ST_COMPLETE;
                    end else if (ctl_ready) begin
                        r_ctl_valid <= 1'b0;
                        r_gnt       <= r_win_oh;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_busy <= 1'b1;
                    if (ctl_done) r_state <= ST_COMPLETE;
                end
                ST_COMPLETE: begin
                    r_busy   <= 1'b0;
                    r_done   <= r_win_oh;
                    r_rr_ptr <= (r_win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : r_win_idx + 1'b1;
                    r_state  <= ST_IDLE;
                end
                ST_REFRESH: begin
                    r_busy <= !aref_done;
                    if (aref_done) begin
                        r_aref_ack <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b1;
                    r_state <= ST_WAIT_INIT;
                end
            endcase
        end
    end

    assign aref_ack  = r_aref_ack;
    assign port_gnt  = r_gnt;
    assign port_done = r_done;
    assign ctl_valid = r_ctl_valid;
    assign ctl_we    = r_we;
    assign ctl_addr  = r_addr;
    assign ctl_len   = r_len;
    assign busy      = r_busy;
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed self-checking bench for sdram_port_arb (4 ports)
module tb_sdram_port_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        aref_req = 1'b0;
    logic        aref_ack;
    logic        aref_done = 1'b0;
    logic [3:0]  port_req = '0;
    logic [3:0]  port_we = 4'b0100;
    logic [95:0] port_addr;
    logic [35:0] port_len;
    logic [3:0]  port_gnt;
    logic [3:0]  port_done;
    logic        ctl_valid;
    logic        ctl_we;
    logic [23:0] ctl_addr;
    logic [8:0]  ctl_len;
    logic        ctl_ready = 1'b0;
    logic        ctl_done = 1'b0;
    logic        busy;

    logic [23:0] a [4];
    logic [8:0]  ln [4];
    int n_tests = 0;
    int n_fail  = 0;
    logic flag;

    always #5 clk = ~clk;

    always_comb begin
        port_addr = '0;
        port_len  = '0;
        for (int i = 0; i < 4; i++) begin
            port_addr[i*24 +: 24] = a[i];
            port_len[i*9 +: 9]    = ln[i];
        end
    end

    sdram_port_arb dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .aref_req(aref_req), .aref_ack(aref_ack), .aref_done(aref_done),
        .port_req(port_req), .port_we(port_we), .port_addr(port_addr), .port_len(port_len),
        .port_gnt(port_gnt), .port_done(port_done),
        .ctl_valid(ctl_valid), .ctl_we(ctl_we), .ctl_addr(ctl_addr), .ctl_len(ctl_len),
        .ctl_ready(ctl_ready), .ctl_done(ctl_done), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 12 && port_gnt == 4'b0; i++) tick();
        chk(tag, 32'(port_gnt), 32'(exp));
    endtask

    // Pulse ctl_done three edges after the handshake edge, then observe port_done
    task automatic finish_burst(input string tag, input logic [3:0] exp);
        tick();
        tick();
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        chk({tag, "_not_early"}, 32'(port_done), 32'h0);
        tick();
        chk(tag, 32'(port_done), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a[0] = 24'h012345; a[1] = 24'h4A0B1C; a[2] = 24'h812340; a[3] = 24'hC00FF0;
        ln[0] = 9'd4; ln[1] = 9'd16; ln[2] = 9'd8; ln[3] = 9'd2;
        tick();
        tick();
        chk("rst_valid", 32'(ctl_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(port_gnt), 0);
        chk("rst_addr", 32'(ctl_addr), 0);

        // 1. init gating
        rst = 1'b0;
        port_req = 4'b0001;
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            flag |= ctl_valid;
        end
        chk("init_gate_valid", 32'(flag), 0);
        init_done = 1'b1;
        tick();
        chk("init_t1_valid", 32'(ctl_valid), 0);
        tick();
        chk("init_t2_valid", 32'(ctl_valid), 1);
        chk("init_t2_addr", 32'(ctl_addr), 32'h012345);
        chk("init_t2_len", 32'(ctl_len), 4);
        chk("init_busy", 32'(busy), 1);
        ctl_ready = 1'b1;
        tick();
        chk("init_gnt", 32'(port_gnt), 32'h1);
        chk("init_valid_drop", 32'(ctl_valid), 0);
        port_req = 4'b0000;
        finish_burst("init_done", 4'b0001);
        chk("idle_busy", 32'(busy), 0);

        // 2. round robin from a fresh pointer
        rst = 1'b1;
        #2;
        rst = 1'b0;
        port_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt($sformatf("rr_gnt%0d", k), 4'(1 << (k % 4)));
            chk($sformatf("rr_addr%0d", k), 32'(ctl_addr), 32'(a[k % 4]));
            chk($sformatf("rr_we%0d", k), 32'(ctl_we), 32'(port_we[k % 4]));
            finish_burst($sformatf("rr_done%0d", k), 4'(1 << (k % 4)));
            chk($sformatf("rr_valid_after_done%0d", k), 32'(ctl_valid), 0);
        end

        // 3. refresh requested while busy on port 1
        wait_gnt("ref_gnt1", 4'b0010);
        aref_req = 1'b1;
        finish_burst("ref_done1", 4'b0010);
        chk("ref_ack_not_yet", 32'(aref_ack), 0);
        tick();
        chk("ref_ack", 32'(aref_ack), 1);
        chk("ref_no_valid", 32'(ctl_valid), 0);
        tick();
        tick();
        chk("ref_hold_ack", 32'(aref_ack), 1);
        chk("ref_hold_gnt", 32'(port_gnt), 0);
        aref_req = 1'b0;
        aref_done = 1'b1;
        tick();
        aref_done = 1'b0;
        chk("ref_ack_drop", 32'(aref_ack), 0);
        wait_gnt("ref_next_gnt2", 4'b0100);
        finish_burst("ref_done2", 4'b0100);

        // 4. zero-length request on port 3
        port_req = 4'b1000;
        ln[3] = 9'd0;
        tick();
        chk("zl_issue_valid", 32'(ctl_valid), 0);
        tick();
        chk("zl_gnt", 32'(port_gnt), 32'h8);
        chk("zl_gnt_valid", 32'(ctl_valid), 0);
        port_req = 4'b0000;
        tick();
        chk("zl_done", 32'(port_done), 32'h8);
        chk("zl_done_valid", 32'(ctl_valid), 0);

        // 5. backpressure with refresh arriving during ISSUE
        ctl_ready = 1'b0;
        port_req = 4'b0010;
        tick();
        tick();
        chk("bp_valid", 32'(ctl_valid), 1);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) aref_req = 1'b1;
            tick();
            flag |= !ctl_valid || ctl_addr != a[1] || ctl_len != ln[1] || port_gnt != 0 || aref_ack;
        end
        chk("bp_stable", 32'(flag), 0);
        ctl_ready = 1'b1;
        tick();
        chk("bp_gnt", 32'(port_gnt), 32'h2);
        port_req = 4'b0000;
        tick();
        chk("bp_busy_ack", 32'(aref_ack), 0);
        finish_burst("bp_done", 4'b0010);
        chk("bp_idle_ack", 32'(aref_ack), 0);
        tick();
        chk("bp_ref_ack", 32'(aref_ack), 1);
        aref_req = 1'b0;
        aref_done = 1'b1;
        tick();
        aref_done = 1'b0;
        chk("bp_ref_ack_drop", 32'(aref_ack), 0);

        // 6. reset while busy on port 2
        port_req = 4'b0101;
        wait_gnt("rb_gnt2", 4'b0100);
        tick();
        rst = 1'b1;
        #1;
        chk("rb_valid", 32'(ctl_valid), 0);
        chk("rb_busy", 32'(busy), 0);
        chk("rb_addr", 32'(ctl_addr), 0);
        chk("rb_ack", 32'(aref_ack), 0);
        tick();
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        chk("rb_no_done", 32'(port_done), 0);
        rst = 1'b0;
        tick();
        chk("rb_no_done2", 32'(port_done), 0);
        tick();
        chk("rb_issue_valid", 32'(ctl_valid), 1);
        chk("rb_issue_addr", 32'(ctl_addr), 32'(a[0]));
        tick();
        chk("rb_gnt0", 32'(port_gnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
